ejtag_dr_chain: RTL and testbench
=================================

Name: ejtag_dr_chain

Overview:
EJTAG data-register bank behind the JTAG TAP's extended scan path (ESCANIN/ESCANOUT). It decodes the EJTAG instruction codes, then captures, shifts and updates the ADDRESS, DATA and CONTROL registers. It also runs the processor-access (PrAcc) handshake between the debug probe and the core's debug-memory fetch path. All logic is in the JTAG_CLOCK domain; core-side inputs arrive already synchronised to JTAG_CLOCK.

Parameters:
ADDR_W, 32, width of the ADDRESS register (<=32).
DATA_W, 32, width of the DATA register and the access data bus.

Ports:
JTAG_CLOCK  in  1  TCK; all state updates on posedge.
reset_N  in  1  asynchronous, active-low reset.
JTAG_IR  in  5  current instruction from the TAP.
JTAG_CAPTURE  in  1  TAP in Capture-DR.
JTAG_SHIFT_DR  in  1  TAP in Shift-DR.
JTAG_UPDATE  in  1  TAP in Update-DR.
JTAG_ESCANIN  in  1  serial data in (TDI) for extended chains.
JTAG_ESCANOUT  out  1  serial data out, LSB of the selected chain (combinational from flops).
CORE_PA_REQ  in  1  core debug-memory access pending (level).
CORE_PA_WR  in  1  pending access is a write.
CORE_PA_ADDR  in  ADDR_W  access address.
CORE_PA_WDATA  in  DATA_W  write data from the core.
CORE_DM  in  1  core is in debug mode.
CORE_RST_OCC  in  1  one-cycle pulse: core reset occurred.
EJC_PA_ACK  out  1  one-cycle access-complete pulse.
EJC_PA_RDATA  out  DATA_W  read data for the core; valid while EJC_PA_ACK=1, held otherwise.
EJC_PRRST  out  1  processor-reset request.
EJC_PROBEN  out  1  probe enable.
EJC_PROBTRAP  out  1  debug exception vector in probe space.
EJC_EJTAGBRK  out  1  debug-break request.

Behaviour:
- IR decode:
  - ADDRESS = 5'b0_1000
  - DATA = 5'b0_1001
  - CONTROL = 5'b0_1010
  - ALL = 5'b0_1011; chain order TDI->CONTROL->DATA->ADDRESS->ESCANOUT.
  - Any other code selects a 1-bit bypass flop, reset 0.
- Capture (posedge, JTAG_CAPTURE=1):
  - addr_sr <= addr_hold.
  - data_sr <= data_hold.
  - ctrl_sr <= control image.
- Shift (posedge, JTAG_SHIFT_DR=1): selected register(s) shift right, MSB <= ESCANIN; for ALL, ctrl_sr[0] feeds data_sr MSB and data_sr[0] feeds addr_sr MSB.
- Update (posedge, JTAG_UPDATE=1):
  - DATA or ALL: data_hold <= data_sr.
  - CONTROL or ALL: writable control bits from ctrl_sr.
  - ADDRESS is read-only; its update is ignored.
- Control image; all bits not listed read 0:
  - [31] Rocc: set by CORE_RST_OCC; cleared by writing 0; set has priority over clear in the same cycle.
  - [19] PRnW = CORE_PA_WR (RO).
  - [18] PrAcc: RO 1 while state=PEND; writing 0 in PEND completes the access.
  - [16] PrRst, [15] ProbEn, [14] ProbTrap: R/W.
  - [12] EjtagBrk: writing 1 sets; writing 0 has no effect; cleared on the cycle CORE_DM rises.
  - [3] DM = CORE_DM (RO).
- PrAcc FSM:
  - IDLE -> PEND when CORE_PA_REQ=1 and ProbEn=1. On entry, addr_hold <= CORE_PA_ADDR; if CORE_PA_WR, data_hold <= CORE_PA_WDATA.
  - PEND -> ACK on a CONTROL/ALL update with ctrl_sr[18]=0. Writing 1 leaves PEND.
  - ACK lasts one cycle: EJC_PA_ACK=1, EJC_PA_RDATA <= data_hold (captured on the ACK cycle).
  - ACK -> DROP. DROP -> IDLE when CORE_PA_REQ=0.
  - A PrAcc=0 write in IDLE/ACK/DROP is ignored.
  - ProbEn cleared while in PEND: stay in PEND (no spontaneous abort).
- Reset values:
  - All shift/hold registers 0; FSM IDLE.
  - EJC_PA_ACK=0, EJC_PA_RDATA=0, EJC_PRRST=0, EJC_PROBEN=0, EJC_PROBTRAP=0, EJC_EJTAGBRK=0.
  - Rocc resets to 1.
- Reset mid-access: the in-flight access is discarded. If CORE_PA_REQ is still high and ProbEn=1, a new PEND starts. Because ProbEn resets to 0, no access is claimed until the probe re-enables it.
- Capture and update never coincide (TAP state exclusivity); no arbitration between them is required.

Test Plan:
- Reset, IR=CONTROL, capture+shift 32 -> ESCANOUT stream equals 0x8000_0000 LSB first (Rocc=1, DM=0); all EJC_* outputs 0.
- IR=CONTROL, shift in 0x0000_8000 and update; then CORE_PA_REQ=1, WR=0, ADDR=0xFF20_0200 -> PrAcc reads 1; an ADDRESS scan returns 0xFF20_0200.
- From that PEND: DATA scan-in 0x3C01_FF20, then CONTROL write 0x0000_8000 -> EJC_PA_ACK pulses exactly one cycle with EJC_PA_RDATA=0x3C01_FF20; a later CONTROL scan shows PrAcc=0.
- Core write access, WDATA=0xDEAD_BEEF -> a DATA scan captures 0xDEAD_BEEF and PRnW=1.
- IR=ALL, shift 96 bits -> the ADDRESS LSB exits first, and the bit fed in first emerges after 96 shifts.
- Write EjtagBrk=1 -> EJC_EJTAGBRK=1; raise CORE_DM -> EJC_EJTAGBRK clears that cycle.
- Assert reset_N low while in PEND -> FSM IDLE, EJC_PROBEN=0, no ACK.
- IR=5'b0_0011: ESCANIN=1 -> ESCANOUT=1 after one shift.

Source files
------------

// File: rtl/ejtag_dr_chain_if.sv
// Processor-access (PrAcc) bus between the core's debug-memory fetch path
// and the EJTAG data-register bank. The core issues the access (master);
// the EJTAG block completes it (slave).
interface ejtag_dr_chain_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              CORE_PA_REQ;
  logic              CORE_PA_WR;
  logic [ADDR_W-1:0] CORE_PA_ADDR;
  logic [DATA_W-1:0] CORE_PA_WDATA;
  logic              EJC_PA_ACK;
  logic [DATA_W-1:0] EJC_PA_RDATA;

  modport master (
    output CORE_PA_REQ, CORE_PA_WR, CORE_PA_ADDR, CORE_PA_WDATA,
    input  EJC_PA_ACK, EJC_PA_RDATA
  );

  modport slave (
    input  CORE_PA_REQ, CORE_PA_WR, CORE_PA_ADDR, CORE_PA_WDATA,
    output EJC_PA_ACK, EJC_PA_RDATA
  );
endinterface

// File: rtl/ejtag_dr_chain.sv
// EJTAG data-register bank: ADDRESS / DATA / CONTROL scan registers on the
// extended scan path, plus the PrAcc handshake that lets the probe service
// the core's debug-memory accesses.
module ejtag_dr_chain #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       JTAG_CLOCK,
  input  logic       reset_N,
  input  logic [4:0] JTAG_IR,
  input  logic       JTAG_CAPTURE,
  input  logic       JTAG_SHIFT_DR,
  input  logic       JTAG_UPDATE,
  input  logic       JTAG_ESCANIN,
  output logic       JTAG_ESCANOUT,
  input  logic       CORE_DM,
  input  logic       CORE_RST_OCC,
  output logic       EJC_PRRST,
  output logic       EJC_PROBEN,
  output logic       EJC_PROBTRAP,
  output logic       EJC_EJTAGBRK,
  ejtag_dr_chain_if.slave pa
);

  localparam logic [4:0] IR_ADDRESS = 5'b0_1000;
  localparam logic [4:0] IR_DATA    = 5'b0_1001;
  localparam logic [4:0] IR_CONTROL = 5'b0_1010;
  localparam logic [4:0] IR_ALL     = 5'b0_1011;

  // Bit positions inside the CONTROL register
  localparam int B_ROCC     = 31;
  localparam int B_PRNW     = 19;
  localparam int B_PRACC    = 18;
  localparam int B_PRRST    = 16;
  localparam int B_PROBEN   = 15;
  localparam int B_PROBTRAP = 14;
  localparam int B_EJTAGBRK = 12;
  localparam int B_DM       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_ACK,
    ST_DROP
  } pa_state_t;

  pa_state_t         state_reg;

  logic [ADDR_W-1:0] addr_sr_reg;
  logic [DATA_W-1:0] data_sr_reg;
  logic [31:0]       ctrl_sr_reg;
  logic              bypass_reg;

  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] data_hold_reg;

  logic              rocc_reg;
  logic              prrst_reg;
  logic              proben_reg;
  logic              probtrap_reg;
  logic              ejtagbrk_reg;
  logic              dm_prev_reg;

  logic              ack_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              sel_addr;
  logic              sel_data;
  logic              sel_ctrl;
  logic              sel_all;
  logic              upd_ctrl;
  logic              upd_data;
  logic              dm_rise;
  logic [31:0]       ctrl_image;

  assign sel_addr = (JTAG_IR == IR_ADDRESS);
  assign sel_data = (JTAG_IR == IR_DATA);
  assign sel_ctrl = (JTAG_IR == IR_CONTROL);
  assign sel_all  = (JTAG_IR == IR_ALL);

  assign upd_ctrl = JTAG_UPDATE && (sel_ctrl || sel_all);
  assign upd_data = JTAG_UPDATE && (sel_data || sel_all);
  assign dm_rise  = CORE_DM && !dm_prev_reg;

  // Live view of the CONTROL register as seen by Capture-DR
  always_comb begin
    ctrl_image             = '0;
    ctrl_image[B_ROCC]     = rocc_reg;
    ctrl_image[B_PRNW]     = pa.CORE_PA_WR;
    ctrl_image[B_PRACC]    = (state_reg == ST_PEND);
    ctrl_image[B_PRRST]    = prrst_reg;
    ctrl_image[B_PROBEN]   = proben_reg;
    ctrl_image[B_PROBTRAP] = probtrap_reg;
    ctrl_image[B_EJTAGBRK] = ejtagbrk_reg;
    ctrl_image[B_DM]       = CORE_DM;
  end

  // Capture and shift of the scan registers; ALL concatenates CONTROL->DATA->ADDRESS
  always_ff @(posedge JTAG_CLOCK or negedge reset_N) begin
    if (!reset_N) begin
      addr_sr_reg <= '0;
      data_sr_reg <= '0;
      ctrl_sr_reg <= '0;
      bypass_reg  <= 1'b0;
    end else if (JTAG_CAPTURE) begin
      addr_sr_reg <= addr_hold_reg;
      data_sr_reg <= data_hold_reg;
      ctrl_sr_reg <= ctrl_image;
      bypass_reg  <= 1'b0;
    end else if (JTAG_SHIFT_DR) begin
      if (sel_addr) begin
        addr_sr_reg <= {JTAG_ESCANIN, addr_sr_reg[ADDR_W-1:1]};
      end else if (sel_data) begin
        data_sr_reg <= {JTAG_ESCANIN, data_sr_reg[DATA_W-1:1]};
      end else if (sel_ctrl) begin
        ctrl_sr_reg <= {JTAG_ESCANIN, ctrl_sr_reg[31:1]};
      end else if (sel_all) begin
        ctrl_sr_reg <= {JTAG_ESCANIN, ctrl_sr_reg[31:1]};
        data_sr_reg <= {ctrl_sr_reg[0], data_sr_reg[DATA_W-1:1]};
        addr_sr_reg <= {data_sr_reg[0], addr_sr_reg[ADDR_W-1:1]};
      end else begin
        bypass_reg  <= JTAG_ESCANIN;
      end
    end
  end

  // Serial output: LSB of the selected chain (ADDRESS is the tail of ALL)
  always_comb begin
    JTAG_ESCANOUT = bypass_reg;
    if (sel_addr || sel_all) begin
      JTAG_ESCANOUT = addr_sr_reg[0];
    end else if (sel_data) begin
      JTAG_ESCANOUT = data_sr_reg[0];
    end else if (sel_ctrl) begin
      JTAG_ESCANOUT = ctrl_sr_reg[0];
    end
  end

  // Writable CONTROL bits, reset-occurred flag and debug-break request
  always_ff @(posedge JTAG_CLOCK or negedge reset_N) begin
    if (!reset_N) begin
      rocc_reg     <= 1'b1;
      prrst_reg    <= 1'b0;
      proben_reg   <= 1'b0;
      probtrap_reg <= 1'b0;
      ejtagbrk_reg <= 1'b0;
      dm_prev_reg  <= 1'b0;
    end else begin
      dm_prev_reg <= CORE_DM;
      // A fresh reset event must never be lost to a simultaneous clear
      if (CORE_RST_OCC) begin
        rocc_reg <= 1'b1;
      end else if (upd_ctrl && !ctrl_sr_reg[B_ROCC]) begin
        rocc_reg <= 1'b0;
      end
      if (upd_ctrl) begin
        prrst_reg    <= ctrl_sr_reg[B_PRRST];
        proben_reg   <= ctrl_sr_reg[B_PROBEN];
        probtrap_reg <= ctrl_sr_reg[B_PROBTRAP];
      end
      // Entering debug mode means the break was taken; that wins over a new request
      if (dm_rise) begin
        ejtagbrk_reg <= 1'b0;
      end else if (upd_ctrl && ctrl_sr_reg[B_EJTAGBRK]) begin
        ejtagbrk_reg <= 1'b1;
      end
    end
  end

  // PrAcc handshake FSM with the ADDRESS/DATA holding registers it owns
  always_ff @(posedge JTAG_CLOCK or negedge reset_N) begin
    if (!reset_N) begin
      state_reg     <= ST_IDLE;
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
      ack_reg       <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      ack_reg <= 1'b0;
      if (upd_data) begin
        data_hold_reg <= data_sr_reg;
      end
      case (state_reg)
        ST_IDLE: begin
          if (pa.CORE_PA_REQ && proben_reg) begin
            state_reg     <= ST_PEND;
            addr_hold_reg <= pa.CORE_PA_ADDR;
            // Core write data takes precedence over a coincident DATA update
            if (pa.CORE_PA_WR) begin
              data_hold_reg <= pa.CORE_PA_WDATA;
            end
          end
        end
        ST_PEND: begin
          if (upd_ctrl && !ctrl_sr_reg[B_PRACC]) begin
            state_reg <= ST_ACK;
            ack_reg   <= 1'b1;
            // An ALL update delivers the data in the same cycle as the release
            rdata_reg <= upd_data ? data_sr_reg : data_hold_reg;
          end
        end
        ST_ACK: begin
          state_reg <= ST_DROP;
        end
        ST_DROP: begin
          if (!pa.CORE_PA_REQ) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign pa.EJC_PA_ACK   = ack_reg;
  assign pa.EJC_PA_RDATA = rdata_reg;
  assign EJC_PRRST       = prrst_reg;
  assign EJC_PROBEN      = proben_reg;
  assign EJC_PROBTRAP    = probtrap_reg;
  assign EJC_EJTAGBRK    = ejtagbrk_reg;

endmodule

// File: tb/tb_ejtag_dr_chain.sv
// Bench for ejtag_dr_chain: a table of scan transactions with expected
// captured values, plus hand-written sequences for ALL, EjtagBrk, Rocc,
// reset-during-access and bypass. Acks are checked by a scoreboard queue.
module tb_ejtag_dr_chain;

  localparam logic [4:0] IR_ADDRESS = 5'b0_1000;
  localparam logic [4:0] IR_DATA    = 5'b0_1001;
  localparam logic [4:0] IR_CONTROL = 5'b0_1010;
  localparam logic [4:0] IR_ALL     = 5'b0_1011;
  localparam logic [4:0] IR_BYPASS  = 5'b0_0011;
  localparam int NROWS = 15;

  logic       clk;
  logic       reset_N;
  logic [4:0] JTAG_IR;
  logic       JTAG_CAPTURE;
  logic       JTAG_SHIFT_DR;
  logic       JTAG_UPDATE;
  logic       JTAG_ESCANIN;
  logic       JTAG_ESCANOUT;
  logic       CORE_DM;
  logic       CORE_RST_OCC;
  logic       EJC_PRRST;
  logic       EJC_PROBEN;
  logic       EJC_PROBTRAP;
  logic       EJC_EJTAGBRK;

  int checks   = 0;
  int failures = 0;
  int ack_run  = 0;

  logic [31:0] ack_q[$];
  logic [31:0] scan_q[$];

  ejtag_dr_chain_if #(.ADDR_W(32), .DATA_W(32)) pa ();

  ejtag_dr_chain #(.ADDR_W(32), .DATA_W(32)) dut (
    .JTAG_CLOCK   (clk),
    .reset_N      (reset_N),
    .JTAG_IR      (JTAG_IR),
    .JTAG_CAPTURE (JTAG_CAPTURE),
    .JTAG_SHIFT_DR(JTAG_SHIFT_DR),
    .JTAG_UPDATE  (JTAG_UPDATE),
    .JTAG_ESCANIN (JTAG_ESCANIN),
    .JTAG_ESCANOUT(JTAG_ESCANOUT),
    .CORE_DM      (CORE_DM),
    .CORE_RST_OCC (CORE_RST_OCC),
    .EJC_PRRST    (EJC_PRRST),
    .EJC_PROBEN   (EJC_PROBEN),
    .EJC_PROBTRAP (EJC_PROBTRAP),
    .EJC_EJTAGBRK (EJC_EJTAGBRK),
    .pa           (pa.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  ir;
    logic [31:0] din;
    logic        upd;
    logic [31:0] exp;
    logic        ack_exp;
    logic [31:0] ack_data;
    logic [3:0]  flags;   // {PRRST, PROBEN, PROBTRAP, EJTAGBRK} after the row
  } vec_t;

  vec_t vecs [NROWS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Capture-DR, nbits of Shift-DR (LSB-first sampling), optional Update-DR
  task automatic scan(input logic [4:0] ir, input int nbits, input logic [191:0] din,
                      input logic upd, output logic [191:0] dout);
    dout = '0;
    JTAG_IR = ir;
    JTAG_CAPTURE = 1'b1;
    tick();
    JTAG_CAPTURE = 1'b0;
    JTAG_SHIFT_DR = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      JTAG_ESCANIN = din[i];
      dout[i] = JTAG_ESCANOUT;
      tick();
    end
    JTAG_SHIFT_DR = 1'b0;
    JTAG_ESCANIN = 1'b0;
    if (upd) begin
      JTAG_UPDATE = 1'b1;
      tick();
      JTAG_UPDATE = 1'b0;
    end
  endtask

  // 32-bit scan whose expected capture goes through the scan scoreboard
  task automatic scan32(input string name, input logic [4:0] ir, input logic [31:0] din,
                        input logic upd, input logic [31:0] exp);
    logic [191:0] dout;
    logic [31:0]  want;
    scan_q.push_back(exp);
    scan(ir, 32, 192'(din), upd, dout);
    want = scan_q.pop_front();
    $display("scan %s ir=%b in=%h out=%h", name, ir, din, dout[31:0]);
    check(name, 192'(dout[31:0]), 192'(want));
  endtask

  function automatic logic [3:0] flags_now();
    return {EJC_PRRST, EJC_PROBEN, EJC_PROBTRAP, EJC_EJTAGBRK};
  endfunction

  // Ack monitor: each pulse pops the expected read data; pulses must be one cycle
  always @(negedge clk) begin
    if (pa.EJC_PA_ACK === 1'b1) begin
      ack_run++;
      if (ack_run == 1) begin
        checks++;
        if (ack_q.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected got=ack rdata=%h exp=no_ack", pa.EJC_PA_RDATA);
        end else begin
          logic [31:0] want;
          want = ack_q.pop_front();
          $display("ack rdata=%h", pa.EJC_PA_RDATA);
          if (pa.EJC_PA_RDATA !== want) begin
            failures++;
            $display("FAIL ack_rdata got=%h exp=%h", pa.EJC_PA_RDATA, want);
          end
        end
      end
    end else if (ack_run != 0) begin
      checks++;
      if (ack_run != 1) begin
        failures++;
        $display("FAIL ack_width got=%0d exp=1", ack_run);
      end
      ack_run = 0;
    end
  end

  initial begin
    logic [191:0] dout;
    logic [191:0] din;
    logic [95:0]  in96;

    //          req  wr   addr          wdata         ir          din           upd  exp           ack  ack_data      flags
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0,        1'b0, 32'h8000_0000, 1'b0, 32'h0,        4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0000_8000, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'b0100};
    vecs[2]  = '{1'b1, 1'b0, 32'hFF20_0200, 32'h0,        IR_CONTROL, 32'h0,        1'b0, 32'h0004_8000, 1'b0, 32'h0,        4'b0100};
    vecs[3]  = '{1'b1, 1'b0, 32'hFF20_0200, 32'h0,        IR_ADDRESS, 32'h0,        1'b1, 32'hFF20_0200, 1'b0, 32'h0,        4'b0100};
    vecs[4]  = '{1'b1, 1'b0, 32'hFF20_0200, 32'h0,        IR_DATA,    32'h3C01_FF20, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        4'b0100};
    vecs[5]  = '{1'b1, 1'b0, 32'hFF20_0200, 32'h0,        IR_CONTROL, 32'h0000_8000, 1'b1, 32'h0004_8000, 1'b1, 32'h3C01_FF20, 4'b0100};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0,        1'b0, 32'h0000_8000, 1'b0, 32'h0,        4'b0100};
    vecs[7]  = '{1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, IR_DATA,    32'h0,        1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,        4'b0100};
    vecs[8]  = '{1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, IR_CONTROL, 32'h0,        1'b0, 32'h000C_8000, 1'b0, 32'h0,        4'b0100};
    vecs[9]  = '{1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, IR_ADDRESS, 32'h0,        1'b0, 32'h1234_5678, 1'b0, 32'h0,        4'b0100};
    vecs[10] = '{1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, IR_CONTROL, 32'h0000_8000, 1'b1, 32'h000C_8000, 1'b1, 32'hDEAD_BEEF, 4'b0100};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0,        1'b0, 32'h0000_8000, 1'b0, 32'h0,        4'b0100};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0000_C000, 1'b1, 32'h0000_8000, 1'b0, 32'h0,        4'b0110};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0001_C000, 1'b1, 32'h0000_C000, 1'b0, 32'h0,        4'b1110};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h0,        IR_CONTROL, 32'h0000_8000, 1'b1, 32'h0001_C000, 1'b0, 32'h0,        4'b0100};

    reset_N = 1'b0;
    JTAG_IR = 5'b0;
    JTAG_CAPTURE = 1'b0;
    JTAG_SHIFT_DR = 1'b0;
    JTAG_UPDATE = 1'b0;
    JTAG_ESCANIN = 1'b0;
    CORE_DM = 1'b0;
    CORE_RST_OCC = 1'b0;
    pa.CORE_PA_REQ = 1'b0;
    pa.CORE_PA_WR = 1'b0;
    pa.CORE_PA_ADDR = '0;
    pa.CORE_PA_WDATA = '0;
    tick();
    tick();
    reset_N = 1'b1;
    tick();

    check("reset_flags", 192'(flags_now()), 192'(4'b0000));
    check("reset_ack", 192'(pa.EJC_PA_ACK), 192'(1'b0));
    check("reset_rdata", 192'(pa.EJC_PA_RDATA), 192'(32'h0));

    // Table-driven scan transactions
    for (int r = 0; r < NROWS; r++) begin
      pa.CORE_PA_REQ   = vecs[r].req;
      pa.CORE_PA_WR    = vecs[r].wr;
      pa.CORE_PA_ADDR  = vecs[r].addr;
      pa.CORE_PA_WDATA = vecs[r].wdata;
      tick();
      tick();
      if (vecs[r].ack_exp) ack_q.push_back(vecs[r].ack_data);
      scan32($sformatf("row%0d", r), vecs[r].ir, vecs[r].din, vecs[r].upd, vecs[r].exp);
      check($sformatf("row%0d_flags", r), 192'(flags_now()), 192'(vecs[r].flags));
    end
    tick();
    tick();

    // ALL chain: ADDRESS LSB first, then bits fed in reappear after 96 shifts
    in96 = {$urandom(), $urandom(), $urandom()};
    din = {96'h0, in96};
    scan(IR_ALL, 192, din, 1'b0, dout);
    $display("scan all first96=%h last96=%h", dout[95:0], dout[191:96]);
    check("all_capture", 192'(dout[95:0]), 192'({32'h0000_8000, 32'hDEAD_BEEF, 32'h1234_5678}));
    check("all_passthru", 192'(dout[191:96]), 192'(in96));

    // EjtagBrk: set by write, cleared on CORE_DM rising edge
    scan32("brk_write", IR_CONTROL, 32'h0000_9000, 1'b1, 32'h0000_8000);
    check("brk_set", 192'(EJC_EJTAGBRK), 192'(1'b1));
    CORE_DM = 1'b1;
    tick();
    check("brk_clear_on_dm", 192'(EJC_EJTAGBRK), 192'(1'b0));
    scan32("dm_read", IR_CONTROL, 32'h0, 1'b0, 32'h0000_8008);
    CORE_DM = 1'b0;
    tick();

    // Rocc set by a core reset pulse
    CORE_RST_OCC = 1'b1;
    tick();
    CORE_RST_OCC = 1'b0;
    tick();
    scan32("rocc_set", IR_CONTROL, 32'h0, 1'b0, 32'h8000_8000);

    // Reset while an access is pending
    pa.CORE_PA_REQ  = 1'b1;
    pa.CORE_PA_WR   = 1'b0;
    pa.CORE_PA_ADDR = 32'hA5A5_0000;
    tick();
    tick();
    scan32("pend_before_rst", IR_CONTROL, 32'h0, 1'b0, 32'h8004_8000);
    reset_N = 1'b0;
    tick();
    tick();
    reset_N = 1'b1;
    tick();
    check("rst_flags", 192'(flags_now()), 192'(4'b0000));
    check("rst_rdata", 192'(pa.EJC_PA_RDATA), 192'(32'h0));
    scan32("rst_ctrl", IR_CONTROL, 32'h0, 1'b0, 32'h8000_0000);
    scan32("rst_addr", IR_ADDRESS, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    pa.CORE_PA_REQ = 1'b0;
    tick();

    // Bypass flop: one cycle of delay
    scan(IR_BYPASS, 2, 192'(2'b01), 1'b0, dout);
    $display("scan bypass in=01 out=%b", dout[1:0]);
    check("bypass_one", 192'(dout[1:0]), 192'(2'b10));
    scan(IR_BYPASS, 2, 192'(2'b10), 1'b0, dout);
    $display("scan bypass in=10 out=%b", dout[1:0]);
    check("bypass_zero", 192'(dout[1:0]), 192'(2'b00));

    tick();
    tick();
    check("acks_outstanding", 192'(ack_q.size()), 192'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
